// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for the 5-stage core.
// Handles three cases:
//   - load-use hazards, with a one-cycle combinational stall;
//   - mul/div operations, with a counted EX stall;
//   - taken branches, with an IF/ID flush and an ID/EX bubble.
// Optional macro HAZARD_PERF_EN adds three saturating 16-bit performance counters.
module hazard_ctrl #(
    parameter int unsigned MULDIV_LAT = 4,
    parameter int unsigned CNT_W      = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       id_valid,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rt,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rt,
    input  logic       ex_muldiv,
    input  logic       ex_branch_taken,
    output logic       pc_write,
    output logic       ifid_write,
    output logic       ifid_flush,
    output logic       idex_bubble,
    output logic       idex_hold,
    output logic       muldiv_done,
`ifdef HAZARD_PERF_EN
    output logic       busy,
    output logic [15:0] perf_ldstall_cnt,
    output logic [15:0] perf_md_cnt,
    output logic [15:0] perf_flush_cnt
`else
    output logic       busy
`endif
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        MDBUSY = 2'd1,
        MDDONE = 2'd2
    } state_t;

    state_t             state, state_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic               ldh;

    // Load-use detection; register 0 never creates a dependency
    always_comb begin
        ldh = id_valid & ex_mem_read & (ex_rt != 5'd0) &
              ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));
    end

    // State and latency counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Next-state logic: a mul/div accepted in RUN spends MULDIV_LAT-1 cycles in MDBUSY
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            RUN: begin
                if (!ex_branch_taken && ex_muldiv) begin
                    state_nx = MDBUSY;
                    cnt_nx   = CNT_W'(MULDIV_LAT - 2);
                end
            end
            MDBUSY: begin
                if (cnt == '0) begin
                    state_nx = MDDONE;
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            MDDONE:  state_nx = RUN;
            default: state_nx = RUN;
        endcase
    end

    // Output decode; all outputs are forced low while reset is asserted
    always_comb begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        idex_hold   = 1'b0;
        muldiv_done = 1'b0;
        busy        = 1'b0;
        if (!rst) begin
            case (state)
                RUN: begin
                    if (ex_branch_taken) begin
                        ifid_flush  = 1'b1;
                        idex_bubble = 1'b1;
                        pc_write    = 1'b1;
                        ifid_write  = 1'b1;
                    end else if (ex_muldiv) begin
                        idex_hold = 1'b1;
                    end else if (ldh) begin
                        idex_bubble = 1'b1;
                    end else begin
                        pc_write   = 1'b1;
                        ifid_write = 1'b1;
                    end
                end
                MDBUSY: begin
                    idex_hold = 1'b1;
                    busy      = 1'b1;
                end
                MDDONE: begin
                    muldiv_done = 1'b1;
                    busy        = 1'b1;
                    if (ldh) begin
                        idex_bubble = 1'b1;
                    end else begin
                        pc_write   = 1'b1;
                        ifid_write = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef HAZARD_PERF_EN
    logic ldstall;

    // A load-use stall is a bubble without a flush
    always_comb begin
        ldstall = idex_bubble & ~ifid_flush;
    end

    // Saturating event counters
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_ldstall_cnt <= '0;
            perf_md_cnt      <= '0;
            perf_flush_cnt   <= '0;
        end else begin
            if (ldstall && perf_ldstall_cnt != '1)
                perf_ldstall_cnt <= perf_ldstall_cnt + 16'd1;
            if (muldiv_done && perf_md_cnt != '1)
                perf_md_cnt <= perf_md_cnt + 16'd1;
            if (ifid_flush && perf_flush_cnt != '1)
                perf_flush_cnt <= perf_flush_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: self-checking bench for hazard_ctrl.
// Directed cases check literal expectations. Randomized traffic is checked every cycle
// against a timeline model that tracks the number of cycles elapsed since a mul/div
// op was accepted.
module tb_hazard_ctrl;
    localparam int LAT = 4;

    logic       clk = 1'b0;
    logic       rst, id_valid, id_uses_rt, ex_mem_read, ex_muldiv, ex_branch_taken;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       pc_write, ifid_write, ifid_flush, idex_bubble, idex_hold, muldiv_done, busy;
`ifdef HAZARD_PERF_EN
    logic [15:0] perf_ldstall_cnt, perf_md_cnt, perf_flush_cnt;
    int          m_ld, m_md, m_fl;
`endif

    int vectors = 0;
    int miscompares = 0;
    int phase = 0;           // 0 = idle, k = k-th cycle after the op was accepted
    bit done_seen;

    hazard_ctrl #(.MULDIV_LAT(LAT), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
        .ex_muldiv(ex_muldiv), .ex_branch_taken(ex_branch_taken),
        .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .idex_bubble(idex_bubble), .idex_hold(idex_hold), .muldiv_done(muldiv_done),
`ifdef HAZARD_PERF_EN
        .busy(busy), .perf_ldstall_cnt(perf_ldstall_cnt), .perf_md_cnt(perf_md_cnt),
        .perf_flush_cnt(perf_flush_cnt)
`else
        .busy(busy)
`endif
    );

    always #5 clk = ~clk;

    // Output vector order: {pc_write, ifid_write, ifid_flush, idex_bubble, idex_hold, muldiv_done, busy}
    wire [6:0] outs = {pc_write, ifid_write, ifid_flush, idex_bubble, idex_hold, muldiv_done, busy};

    function automatic logic model_ldh();
        return id_valid && ex_mem_read && ex_rt != 0 &&
               (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt));
    endfunction

    function automatic logic [6:0] model_out();
        if (rst) return 7'b0;
        if (phase == 0) begin
            if (ex_branch_taken) return 7'b1111000;
            if (ex_muldiv)       return 7'b0000100;
            if (model_ldh())     return 7'b0001000;
            return 7'b1100000;
        end
        if (phase < LAT) return 7'b0000101;
        return model_ldh() ? 7'b0001011 : 7'b1100011;
    endfunction

    // Per-cycle comparison against the model, followed by a model advance to the next cycle
    always @(negedge clk) begin
        logic [6:0] e;
        e = model_out();
        vectors++;
        if (outs !== e) begin
            miscompares++;
            $display("FAIL cycle t=%0t outs=%b expected=%b phase=%0d", $time, outs, e, phase);
        end
        if (muldiv_done) done_seen = 1'b1;
`ifdef HAZARD_PERF_EN
        vectors++;
        if (perf_ldstall_cnt !== 16'(m_ld) || perf_md_cnt !== 16'(m_md) || perf_flush_cnt !== 16'(m_fl)) begin
            miscompares++;
            $display("FAIL perf t=%0t got=%0d/%0d/%0d expected=%0d/%0d/%0d", $time,
                     perf_ldstall_cnt, perf_md_cnt, perf_flush_cnt, m_ld, m_md, m_fl);
        end
        if (rst) begin
            m_ld = 0; m_md = 0; m_fl = 0;
        end else begin
            if (e[3] && !e[4] && m_ld < 65535) m_ld++;
            if (e[1] && m_md < 65535) m_md++;
            if (e[4] && m_fl < 65535) m_fl++;
        end
`endif
        if (rst)                                  phase = 0;
        else if (phase == 0)                      phase = (!ex_branch_taken && ex_muldiv) ? 1 : 0;
        else if (phase < LAT)                     phase = phase + 1;
        else                                      phase = 0;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Advance to just after the next rising edge, then drive
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_valid = 0; id_rs = 0; id_rt = 0; id_uses_rt = 0;
        ex_mem_read = 0; ex_rt = 0; ex_muldiv = 0; ex_branch_taken = 0;
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        #2;
        chk("reset_outs", 32'(outs), 32'h0);
        tick(); tick();
        rst = 0;
        #2;
        chk("run_after_reset", 32'(outs), 32'b1100000);

        // Load-use stall on rs
        tick();
        id_valid = 1; ex_mem_read = 1; ex_rt = 5; id_rs = 5; #2;
        chk("ld_pc", 32'(pc_write), 32'd0);
        chk("ld_ifid", 32'(ifid_write), 32'd0);
        chk("ld_bubble", 32'(idex_bubble), 32'd1);
        tick();
        ex_mem_read = 0; #2;
        chk("ld_release_pc", 32'(pc_write), 32'd1);

        // rt is ignored when not a source; $zero never stalls
        tick();
        idle_inputs();
        id_valid = 1; ex_mem_read = 1; ex_rt = 7; id_rt = 7; id_rs = 1; #2;
        chk("rt_gated", 32'(idex_bubble), 32'd0);
        id_uses_rt = 1; #1;
        chk("rt_used", 32'(idex_bubble), 32'd1);
        tick();
        idle_inputs();
        id_valid = 1; ex_mem_read = 1; ex_rt = 0; id_rs = 0; #2;
        chk("zero_reg", 32'(pc_write), 32'd1);

        // Mul/div timeline, with cycle 0 being the cycle the op is seen
        tick();
        idle_inputs();
        ex_muldiv = 1;
        for (int c = 0; c <= LAT + 1; c++) begin
            if (c > 0) begin tick(); ex_muldiv = 0; end
            #2;
            chk($sformatf("md_hold_c%0d", c), 32'(idex_hold), 32'(c < LAT));
            chk($sformatf("md_done_c%0d", c), 32'(muldiv_done), 32'(c == LAT));
            chk($sformatf("md_busy_c%0d", c), 32'(busy), 32'(c >= 1 && c <= LAT));
        end
        chk("md_pc_after", 32'(pc_write), 32'd1);

        // A branch takes priority over a simultaneous ldh and muldiv
        tick();
        id_valid = 1; ex_mem_read = 1; ex_rt = 3; id_rs = 3; ex_muldiv = 1; ex_branch_taken = 1; #2;
        chk("prio_outs", 32'(outs), 32'b1111000);
        tick();
        idle_inputs(); #2;
        chk("prio_stay_run", 32'(busy), 32'd0);

        // A branch during MDBUSY is ignored
        ex_muldiv = 1;
        tick();
        ex_muldiv = 0; ex_branch_taken = 1; #2;
        chk("br_in_busy_hold", 32'(idex_hold), 32'd1);
        chk("br_in_busy_flush", 32'(ifid_flush), 32'd0);
        ex_branch_taken = 0;
        for (int i = 0; i < LAT + 2; i++) tick();

        // A reset during MDBUSY abandons the op without a done pulse
        ex_muldiv = 1;
        tick(); ex_muldiv = 0;
        tick(); rst = 1; #2;
        chk("rst_mid_outs", 32'(outs), 32'h0);
        tick(); rst = 0; #2;
        chk("rst_mid_run", 32'(busy), 32'd0);
        done_seen = 0;
        for (int i = 0; i < LAT + 2; i++) tick();
        chk("rst_mid_no_done", 32'(done_seen), 32'd0);

        // Randomized traffic, checked by the per-cycle compare process
        for (int i = 0; i < 3000; i++) begin
            tick();
            rst             = ($urandom_range(0, 99) == 0);
            id_valid        = ($urandom_range(0, 3) != 0);
            id_rs           = 5'($urandom_range(0, 3));
            id_rt           = 5'($urandom_range(0, 3));
            id_uses_rt      = 1'($urandom);
            ex_mem_read     = 1'($urandom);
            ex_rt           = 5'($urandom_range(0, 3));
            ex_muldiv       = ($urandom_range(0, 7) == 0);
            ex_branch_taken = ($urandom_range(0, 9) == 0);
        end

`ifdef HAZARD_PERF_EN
        // Counter totals, then saturation of the flush counter
        tick(); rst = 1; idle_inputs();
        tick(); rst = 0;
        for (int i = 0; i < 3; i++) begin
            tick(); idle_inputs(); id_valid = 1; ex_mem_read = 1; ex_rt = 9; id_rs = 9;
        end
        for (int k = 0; k < 2; k++) begin
            tick(); idle_inputs(); ex_muldiv = 1;
            tick(); ex_muldiv = 0;
            for (int i = 0; i < LAT; i++) tick();
        end
        tick(); idle_inputs(); ex_branch_taken = 1;
        tick(); idle_inputs(); #2;
        chk("perf_ld", 32'(perf_ldstall_cnt), 32'd3);
        chk("perf_md", 32'(perf_md_cnt), 32'd2);
        chk("perf_fl", 32'(perf_flush_cnt), 32'd1);
        ex_branch_taken = 1;
        for (int i = 0; i < 65540; i++) tick();
        ex_branch_taken = 0;
        tick(); #2;
        chk("perf_fl_sat", 32'(perf_flush_cnt), 32'hFFFF);
`endif

        tick();
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
